lsu_sequencer: RTL
==================

# lsu_sequencer

Multi-cycle load/store sequencer between the single-cycle core's decode/execute stage and a data RAM with a request/ready handshake. It consumes the decoder's `write_ram_flag` / `read_ram_flag` encodings together with the ALU address and rs2 data. It drives byte-lane strobes and replicated write data, and returns extended load data. It stalls the core until the access completes, a misalignment is detected, or a bus timeout fires.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles in REQ without `mem_ready` before a bus error is declared (≥1).
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: the core presents a memory op; held stable until the `done` cycle.
- `write_ram_flag` in 2: 00 none, 01 sw, 10 sh, 11 sb.
- `read_ram_flag` in 3: 000 none, 001 lw, 010 lhu, 011 lbu, 110 lh, 111 lb; other codes are treated as none.
- `addr` in 32: byte address (ALU result).
- `wdata` in 32: store data (rs2).
- `stall` out 1: freeze PC/regfile write this cycle.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 32: extended load data, valid while `done`.
- `misaligned` out 1: valid with `done`; the access was not issued.
- `bus_err` out 1: valid with `done`; timeout.
- `mem_req` out 1: bus request.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: `{addr[31:2],2'b00}`.
- `mem_wstrb` out 4: byte enables (writes only; 0 on reads).
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ready` in 1: RAM accepted/completed the access this cycle.
- `mem_rdata` in 32: read word, valid when `mem_ready` and `!mem_we`.

## Operation
- **Op present**: `req_valid && (write_ram_flag!=0 || read_ram_flag is a legal code)`.
- **Both flags nonzero**: the store is performed and the read is ignored.
- **FSM states**: IDLE, REQ, DONE.
- **IDLE, op present, aligned**: latch `mem_addr`, `mem_we`, `mem_wstrb`, `mem_wdata`, and the load type; go to REQ; `mem_req`=1 from the next cycle.
- **IDLE, op present, misaligned**: go to DONE with `misaligned`=1 and `rdata`=0; no bus activity.
  - Misaligned means: lw/sw with `addr[1:0]`≠0; lh/lhu/sh with `addr[0]`=1.
- **REQ**:
  - `mem_req` is held with all bus outputs stable.
  - On `mem_ready`: drop `mem_req` at the edge, register `rdata`, go to DONE.
  - Else increment the timeout counter. When it equals `TIMEOUT_CYCLES-1` with no ready: drop `mem_req`, set `bus_err`=1 and `rdata`=0, go to DONE.
- **DONE**: `done`=1 and `stall`=0 for exactly one cycle. Go to IDLE unconditionally; no new op is accepted in DONE.
- **stall**: `(state==IDLE && op present) || state==REQ`; forced 0 while `rst`=1.
- **Store lanes**:
  - sb: `wstrb = 4'b0001<<addr[1:0]`, `mem_wdata = {4{wdata[7:0]}}`.
  - sh: `wstrb = addr[1]?4'b1100:4'b0011`, `mem_wdata = {2{wdata[15:0]}}`.
  - sw: `wstrb` 1111, `mem_wdata = wdata`.
- **Load extract**:
  - Byte = `mem_rdata[8*addr[1:0]+:8]`; half = `mem_rdata[16*addr[1]+:16]`.
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- **Flag clearing**: `misaligned` and `bus_err` clear on leaving DONE.
- **Reset**:
  - State IDLE and timeout counter 0.
  - All outputs 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wstrb`, `mem_wdata`, `rdata`, `done`, `misaligned`, `bus_err`, `stall`.
  - Reset in REQ drops `mem_req` at that edge; the outstanding access is abandoned and a late `mem_ready` in IDLE is ignored.

## Timing
- **Aligned access**: op seen in IDLE at cycle 0; `mem_req` high from cycle 1. If `mem_ready` is high in cycle k (k≥1), `done` is high in cycle k+1, and the core advances at the end of k+1.
- **Minimum latency** (zero-wait RAM): `stall` in cycles 0–1, `done` in cycle 2.
- **Misaligned access**: `stall` in cycle 0, `done` plus `misaligned` in cycle 1.
- **Timeout**: `mem_req` is high for exactly `TIMEOUT_CYCLES` cycles, then `done` plus `bus_err`.
- **Bus output stability**: bus outputs change only on the IDLE→REQ edge and are stable throughout REQ.
- **Back-to-back ops**: the next op is accepted at the earliest in the IDLE cycle after DONE.

## Test plan
- **sb, zero-wait**: addr=0x1003, wdata=0x000000A5, `mem_ready` tied 1 → cycle 1 has `mem_req`=1, `mem_we`=1, `mem_addr`=0x1000, wstrb=1000, `mem_wdata`=0xA5A5A5A5; `done` in cycle 2; stall cycles 0–1.
- **lb/lbu/lh**: `mem_rdata`=0x80F17F00.
  - lb @0x2002 → `rdata`=0xFFFFFFF1.
  - lbu @0x2003 → 0x00000080.
  - lh @0x2002 → 0xFFFF80F1.
- **lw with wait states**: `mem_ready` asserted 3 cycles after `mem_req` rises, `mem_rdata`=0xDEADBEEF → `done` one cycle after `mem_ready`, `rdata`=0xDEADBEEF, bus outputs stable throughout.
- **Misaligned**: lw @0x3002 and sh @0x3001 → no `mem_req` ever; `done` and `misaligned`=1 in cycle 1; `rdata`=0.
- **Timeout**: `TIMEOUT_CYCLES`=4, `mem_ready` held 0 → `mem_req` high for exactly 4 cycles, then `done`=1, `bus_err`=1, then IDLE.
- **Reset mid-REQ, then dual flags**: assert `rst` in the 2nd REQ cycle → all outputs 0 at the next edge; a later `mem_ready` is ignored. Next, `write_ram_flag`=01 with `read_ram_flag`=001 → a write is issued.

Source files
------------

// File: rtl/lsu_sequencer.sv
// Load/store sequencer between the core's execute stage and a data RAM.
// Issues one aligned bus access per op, stalls the core until it finishes.
module lsu_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [1:0]  write_ram_flag,
    input  logic [2:0]  read_ram_flag,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    ld_type_q;
    logic [1:0]    off_q;
    logic          done_q;
    logic          mis_q;
    logic          berr_q;
    logic [31:0]   rdata_q;
    logic          mem_req_q;
    logic          mem_we_q;
    logic [31:0]   mem_addr_q;
    logic [3:0]    mem_wstrb_q;
    logic [31:0]   mem_wdata_q;

    logic        is_st;
    logic        rd_legal;
    logic        op_present;
    logic        mis_c;
    logic [3:0]  wstrb_c;
    logic [31:0] wdata_c;
    logic [7:0]  byte_c;
    logic [15:0] half_c;
    logic [31:0] ld_data_c;

    // Decode the incoming op: legality, alignment, lanes and store data.
    always_comb begin
        is_st    = |write_ram_flag;
        rd_legal = 1'b0;
        mis_c    = 1'b0;
        wstrb_c  = 4'b0000;
        wdata_c  = 32'h0;
        case (read_ram_flag)
            3'b001, 3'b010, 3'b011,
            3'b110, 3'b111: rd_legal = 1'b1;
            default:        rd_legal = 1'b0;
        endcase
        if (is_st) begin
            case (write_ram_flag)
                2'b01: begin
                    mis_c   = |addr[1:0];
                    wstrb_c = 4'b1111;
                    wdata_c = wdata;
                end
                2'b10: begin
                    mis_c   = addr[0];
                    wstrb_c = addr[1] ? 4'b1100 : 4'b0011;
                    wdata_c = {2{wdata[15:0]}};
                end
                default: begin
                    mis_c   = 1'b0;
                    wstrb_c = 4'b0001 << addr[1:0];
                    wdata_c = {4{wdata[7:0]}};
                end
            endcase
        end else begin
            case (read_ram_flag)
                3'b001:         mis_c = |addr[1:0];
                3'b010, 3'b110: mis_c = addr[0];
                default:        mis_c = 1'b0;
            endcase
        end
        op_present = req_valid && (is_st || rd_legal);
    end

    // Pick the addressed lane out of the returned word and extend it.
    always_comb begin
        byte_c = 8'h0;
        unique case (off_q)
            2'd0: byte_c = mem_rdata[7:0];
            2'd1: byte_c = mem_rdata[15:8];
            2'd2: byte_c = mem_rdata[23:16];
            2'd3: byte_c = mem_rdata[31:24];
        endcase
        half_c = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (ld_type_q)
            3'b001:  ld_data_c = mem_rdata;
            3'b010:  ld_data_c = {16'h0, half_c};
            3'b011:  ld_data_c = {24'h0, byte_c};
            3'b110:  ld_data_c = {{16{half_c[15]}}, half_c};
            3'b111:  ld_data_c = {{24{byte_c[7]}}, byte_c};
            default: ld_data_c = 32'h0;
        endcase
    end

    // Sequencer FSM with registered bus and completion outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ld_type_q   <= 3'b000;
            off_q       <= 2'b00;
            done_q      <= 1'b0;
            mis_q       <= 1'b0;
            berr_q      <= 1'b0;
            rdata_q     <= 32'h0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wstrb_q <= 4'b0000;
            mem_wdata_q <= 32'h0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (op_present) begin
                        if (mis_c) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            mis_q   <= 1'b1;
                            rdata_q <= 32'h0;
                        end else begin
                            state_q     <= S_REQ;
                            cnt_q       <= '0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= is_st;
                            mem_addr_q  <= {addr[31:2], 2'b00};
                            mem_wstrb_q <= is_st ? wstrb_c : 4'b0000;
                            mem_wdata_q <= wdata_c;
                            ld_type_q   <= is_st ? 3'b000 : read_ram_flag;
                            off_q       <= addr[1:0];
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        state_q   <= S_DONE;
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        rdata_q   <= ld_data_c;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= S_DONE;
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        berr_q    <= 1'b1;
                        rdata_q   <= 32'h0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    mis_q   <= 1'b0;
                    berr_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign stall = !rst &&
                   ((state_q == S_IDLE && op_present) || state_q == S_REQ);

    assign done       = done_q;
    assign rdata      = rdata_q;
    assign misaligned = mis_q;
    assign bus_err    = berr_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_wdata  = mem_wdata_q;

endmodule
